// File: rtl/direction_queue.sv
// -----------------------------------------------------------------------------
// direction_queue
//
// Purpose:
//   Converts the four raw snake direction pushbuttons into a paced, legal
//   heading stream. Buttons are synchronised and rising-edge detected. The
//   highest-priority edge of a cycle is checked against the reference heading
//   (the last queued entry, or the current heading if the queue is empty).
//   Legal presses are appended to a small FIFO. The FIFO head is applied to
//   'direction' once per game tick, so quick multi-key turns are neither lost
//   nor applied twice within one step.
//
// Ports:
//   clk        in   1   system clock
//   nrst       in   1   asynchronous active-low reset
//   dir_pb     in   4   raw buttons [3]=UP [2]=DOWN [1]=LEFT [0]=RIGHT
//   restart    in   1   synchronous clear (keeps edge-detect history)
//   game_over  in   1   level: freezes stepping, flushes queue, ignores input
//   direction  out  2   current heading 00=RIGHT 01=LEFT 10=DOWN 11=UP
//   move_tick  out  1   one-cycle step strobe, direction valid same cycle
//   q_count    out  N   number of queued entries
//   q_full     out  1   q_count == QUEUE_DEPTH
//   dropped    out  1   one-cycle pulse: a press edge was rejected
// -----------------------------------------------------------------------------
module direction_queue #(
    parameter int TICK_CYCLES = 10_000_000,
    parameter int QUEUE_DEPTH = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                               clk,
    input  logic                               nrst,
    input  logic [3:0]                         dir_pb,
    input  logic                               restart,
    input  logic                               game_over,
    output logic [1:0]                         direction,
    output logic                               move_tick,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   q_count,
    output logic                               q_full,
    output logic                               dropped
);

    localparam int CNT_W = $clog2(TICK_CYCLES);
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int QC_W  = $clog2(QUEUE_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);
    localparam logic [QC_W-1:0]  QC_FULL  = QC_W'(QUEUE_DEPTH);

    // ------------------------------------------------------------------
    // Input synchroniser and rising-edge detector. Not touched by restart
    // or game_over, so a button held across either produces no new edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES*4-1:0] r_sync;
    logic [3:0]               r_prev;
    logic [3:0]               w_sync_out;
    logic [3:0]               w_edge;

    assign w_sync_out = r_sync[SYNC_STAGES*4-1 -: 4];
    assign w_edge     = w_sync_out & ~r_prev;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            if (SYNC_STAGES > 1) begin
                r_sync <= {r_sync[SYNC_STAGES*4-5:0], dir_pb};
            end else begin
                r_sync <= dir_pb;
            end
            r_prev <= w_sync_out;
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;
    logic             r_move_tick;
    logic             r_dropped;
    logic [1:0]       r_dir;
    logic [1:0]       r_q [QUEUE_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [QC_W-1:0]  r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Push / pop decision, all on pre-pop state
    // ------------------------------------------------------------------
    logic             w_has_edge;
    logic [1:0]       w_edge_dir;
    logic [PTR_W-1:0] w_last_idx;
    logic [1:0]       w_ref;
    logic             w_tick_now;
    logic             w_reversal;
    logic             w_same;
    logic             w_full;
    logic             w_reject;
    logic             w_push;
    logic             w_pop;

    // Bit index of the button equals its direction code, so the priority
    // encoder output is the heading directly.
    always_comb begin
        w_has_edge = |w_edge;
        w_edge_dir = 2'b00;
        if (w_edge[3]) begin
            w_edge_dir = 2'b11;
        end else if (w_edge[2]) begin
            w_edge_dir = 2'b10;
        end else if (w_edge[1]) begin
            w_edge_dir = 2'b01;
        end
    end

    assign w_last_idx = (r_tail == '0) ? PTR_LAST : r_tail - PTR_W'(1);
    assign w_ref      = (r_count != '0) ? r_q[w_last_idx] : r_dir;
    assign w_tick_now = (r_cnt == CNT_LAST);

    // Opposite headings share bit 1 and differ in bit 0.
    assign w_reversal = (w_edge_dir[1] == w_ref[1]) && (w_edge_dir[0] != w_ref[0]);
    assign w_same     = (w_edge_dir == w_ref);
    assign w_full     = (r_count == QC_FULL);
    assign w_reject   = w_has_edge && (w_reversal || w_same || w_full);
    assign w_push     = w_has_edge && !w_reject;
    assign w_pop      = w_tick_now && (r_count != '0);

    // ------------------------------------------------------------------
    // Main sequential block: restart outranks game_over outranks normal play.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt       <= '0;
            r_move_tick <= 1'b0;
            r_dropped   <= 1'b0;
            r_dir       <= 2'b00;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_q[i] <= 2'b00;
            end
        end else if (restart) begin
            r_cnt       <= '0;
            r_move_tick <= 1'b0;
            r_dropped   <= 1'b0;
            r_dir       <= 2'b00;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
        end else if (game_over) begin
            // Counter parked at 0 so release restarts a full period.
            r_cnt       <= '0;
            r_move_tick <= 1'b0;
            r_dropped   <= 1'b0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
        end else begin
            r_cnt       <= w_tick_now ? '0 : r_cnt + CNT_W'(1);
            r_move_tick <= w_tick_now;
            r_dropped   <= w_reject;

            if (w_pop) begin
                r_dir  <= r_q[r_head];
                r_head <= ptr_inc(r_head);
            end
            if (w_push) begin
                r_q[r_tail] <= w_edge_dir;
                r_tail      <= ptr_inc(r_tail);
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + QC_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - QC_W'(1);
            end
        end
    end

    assign direction = r_dir;
    assign move_tick = r_move_tick;
    assign q_count   = r_count;
    assign q_full    = (r_count == QC_FULL);
    assign dropped   = r_dropped;

endmodule

// File: tb/tb_direction_queue.sv
// -----------------------------------------------------------------------------
// tb_direction_queue
//
// Purpose:
//   Self-checking bench for direction_queue (TICK_CYCLES=8, QUEUE_DEPTH=2,
//   SYNC_STAGES=2). A behavioural model built on a pin-history queue, a
//   direction queue and an integer tick counter predicts every output after
//   each clock edge; directed scenarios add explicit expectations on top,
//   followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_direction_queue;

    localparam int T = 8;
    localparam int D = 2;
    localparam int S = 2;

    logic       clk;
    logic       nrst;
    logic [3:0] dir_pb;
    logic       restart;
    logic       game_over;
    logic [1:0] direction;
    logic       move_tick;
    logic [1:0] q_count;
    logic       q_full;
    logic       dropped;

    int errors = 0;
    int checks = 0;

    direction_queue #(
        .TICK_CYCLES(T),
        .QUEUE_DEPTH(D),
        .SYNC_STAGES(S)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .dir_pb    (dir_pb),
        .restart   (restart),
        .game_over (game_over),
        .direction (direction),
        .move_tick (move_tick),
        .q_count   (q_count),
        .q_full    (q_full),
        .dropped   (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [3:0] m_hist[$];   // sampled pins, newest first
    logic [1:0] m_q[$];
    logic [1:0] m_dir;
    int         m_cnt;
    bit         m_tick;
    bit         m_drop;

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < S + 2; i++) m_hist.push_back(4'b0000);
        m_q.delete();
        m_dir  = 2'b00;
        m_cnt  = 0;
        m_tick = 0;
        m_drop = 0;
    endtask

    task automatic model_clock();
        logic [3:0] e;
        logic [1:0] d;
        logic [1:0] r;
        logic [1:0] x;
        bit has;
        bit rej;
        bit tick_now;
        m_hist.push_front(dir_pb);
        while (m_hist.size() > S + 2) void'(m_hist.pop_back());
        // pin seen S edges ago is high, the one before it was low
        e = m_hist[S] & ~m_hist[S+1];
        if (restart) begin
            m_dir = 2'b00; m_cnt = 0; m_q.delete(); m_tick = 0; m_drop = 0;
        end else if (game_over) begin
            m_cnt = 0; m_q.delete(); m_tick = 0; m_drop = 0;
        end else begin
            tick_now = (m_cnt == T - 1);
            has = 0;
            d   = 2'b00;
            for (int b = 3; b >= 0; b--) begin
                if (!has && e[b]) begin
                    has = 1;
                    d   = 2'(b);
                end
            end
            r   = (m_q.size() > 0) ? m_q[$] : m_dir;
            x   = d ^ r;
            // x==00 same heading, x==01 reversal, queue full rejects too
            rej = has && ((x[1] == 1'b0) || (m_q.size() == D));
            if (tick_now && m_q.size() > 0) m_dir = m_q.pop_front();
            if (has && !rej) m_q.push_back(d);
            m_cnt  = (m_cnt + 1) % T;
            m_tick = tick_now;
            m_drop = rej;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        chk("direction", 32'(direction), 32'(m_dir));
        chk("move_tick", 32'(move_tick), 32'(m_tick));
        chk("q_count",   32'(q_count),   32'(m_q.size()));
        chk("q_full",    32'(q_full),    32'(m_q.size() == D));
        chk("dropped",   32'(dropped),   32'(m_drop));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_tick(input int maxc, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (move_tick !== 1'b1 && n < maxc);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    task automatic press(input logic [3:0] pins, input int hold);
        dir_pb = pins;
        steps(hold);
        dir_pb = 4'b0000;
    endtask

    int n;
    int cnt_drop;
    int cnt_tick;

    initial begin
        nrst      = 1'b0;
        dir_pb    = 4'b0000;
        restart   = 1'b0;
        game_over = 1'b0;
        model_reset();

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_direction", 32'(direction), 32'd0);
        chk("rst_move_tick", 32'(move_tick), 32'd0);
        chk("rst_q_count",   32'(q_count),   32'd0);
        chk("rst_q_full",    32'(q_full),    32'd0);
        chk("rst_dropped",   32'(dropped),   32'd0);
        nrst = 1'b1;

        // ---- idle: tick every T cycles ----
        wait_tick(20, n);
        chk("first_tick_gap", 32'(n), 32'(T));
        wait_tick(20, n);
        chk("idle_tick_gap", 32'(n), 32'(T));
        chk("idle_direction", 32'(direction), 32'd0);
        steps(3);

        // ---- DOWN then LEFT before the tick ----
        do_restart();
        press(4'b0100, 1);
        step();
        press(4'b0010, 1);
        steps(3);
        chk("two_queued", 32'(q_count), 32'd2);
        chk("two_full", 32'(q_full), 32'd1);
        wait_tick(20, n);
        chk("pop1_found", 32'(move_tick), 32'd1);
        chk("pop1_dir", 32'(direction), 32'b10);
        chk("pop1_count", 32'(q_count), 32'd1);
        wait_tick(20, n);
        chk("pop2_gap", 32'(n), 32'(T));
        chk("pop2_dir", 32'(direction), 32'b01);
        chk("pop2_count", 32'(q_count), 32'd0);
        steps(3);

        // ---- reversal from RIGHT ----
        do_restart();
        press(4'b0010, 1);
        cnt_drop = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (dropped === 1'b1) cnt_drop++;
        end
        chk("rev_dropped_pulses", 32'(cnt_drop), 32'd1);
        chk("rev_q_count", 32'(q_count), 32'd0);
        chk("rev_direction", 32'(direction), 32'd0);
        steps(3);

        // ---- full queue, press on the tick that pops ----
        do_restart();                // step 0, counter 0
        press(4'b1000, 1);           // UP sampled at step 1
        step();                      // step 2
        press(4'b0010, 1);           // LEFT sampled at step 3
        steps(2);                    // steps 4,5
        press(4'b0100, 1);           // DOWN sampled at step 6
        step();                      // step 7
        chk("full_before_tick", 32'(q_count), 32'd2);
        step();                      // step 8: tick pop + DOWN evaluated
        chk("fullpop_tick", 32'(move_tick), 32'd1);
        chk("fullpop_dir", 32'(direction), 32'b11);
        chk("fullpop_dropped", 32'(dropped), 32'd1);
        chk("fullpop_count", 32'(q_count), 32'd1);
        steps(12);

        // ---- UP+RIGHT together from DOWN ----
        do_restart();
        press(4'b0100, 1);
        wait_tick(20, n);
        chk("down_dir", 32'(direction), 32'b10);
        press(4'b1001, 2);
        cnt_drop = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (dropped === 1'b1) cnt_drop++;
        end
        chk("upright_dropped", 32'(cnt_drop), 32'd1);
        chk("upright_count", 32'(q_count), 32'd0);
        chk("upright_dir", 32'(direction), 32'b10);
        steps(3);

        // ---- game_over flush and resume ----
        do_restart();
        press(4'b0100, 1);
        step();
        press(4'b0010, 1);
        steps(2);
        chk("go_pre_count", 32'(q_count), 32'd2);
        game_over = 1'b1;
        step();
        chk("go_flush", 32'(q_count), 32'd0);
        chk("go_no_tick", 32'(move_tick), 32'd0);
        press(4'b1000, 2);
        cnt_tick = 0;
        cnt_drop = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (move_tick === 1'b1) cnt_tick++;
            if (dropped === 1'b1) cnt_drop++;
        end
        chk("go_ticks", 32'(cnt_tick), 32'd0);
        chk("go_drops", 32'(cnt_drop), 32'd0);
        chk("go_dir_hold", 32'(direction), 32'd0);
        game_over = 1'b0;
        wait_tick(20, n);
        chk("go_release_gap", 32'(n), 32'(T));

        // ---- restart mid-period ----
        press(4'b0100, 1);
        wait_tick(20, n);
        chk("pre_restart_dir", 32'(direction), 32'b10);
        steps(3);
        do_restart();
        chk("restart_dir", 32'(direction), 32'd0);
        chk("restart_count", 32'(q_count), 32'd0);
        wait_tick(20, n);
        chk("restart_gap", 32'(n), 32'(T));

        // ---- randomized phase ----
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) dir_pb = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 1) == 1) dir_pb = 4'b0000;
            if ($urandom_range(0, 39) == 0) game_over = ~game_over;
            restart = ($urandom_range(0, 79) == 0);
            step();
        end
        restart   = 1'b0;
        game_over = 1'b0;
        dir_pb    = 4'b0000;
        steps(4);

        // ---- asynchronous reset mid-run ----
        nrst = 1'b0;
        #1;
        chk("async_rst_dir", 32'(direction), 32'd0);
        chk("async_rst_count", 32'(q_count), 32'd0);
        chk("async_rst_tick", 32'(move_tick), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        nrst = 1'b1;
        wait_tick(20, n);
        chk("post_rst_gap", 32'(n), 32'(T));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
